// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: load-use and MDU-busy stalls, branch flush of IF/ID.
// Drives PC / IF/ID / ID/EX controls and keeps a saturating stall counter.
module hazard_stall_unit #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             id_mdu_start,
  input  logic             id_reads_hilo,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MW = $clog2(MDU_LATENCY + 1);

  localparam logic RUN = 1'b0;
  localparam logic MDU = 1'b1;

  logic             state_q, state_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic load_use;
  logic mdu_hold;
  logic stall;
  logic issue;
  logic last;

  assign load_use = idex_memread
                  & (idex_rt != 5'd0)
                  & ((idex_rt == id_rs)
                  | (id_uses_rt & (idex_rt == id_rt)));

  assign mdu_hold = (state_q == MDU)
                  & (id_mdu_start | id_reads_hilo);

  assign stall = (load_use | mdu_hold) & ~ex_branch_taken;
  assign issue = (state_q == RUN) & id_mdu_start
               & ~stall & ~ex_branch_taken;
  assign last  = (mcnt_q == MW'(1));

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      RUN: begin
        if (issue) begin
          state_d = MDU;
          mcnt_d  = MW'(MDU_LATENCY);
        end
      end
      MDU: begin
        if (last) begin
          state_d = RUN;
          mcnt_d  = '0;
        end else begin
          mcnt_d = mcnt_q - MW'(1);
        end
      end
      default: begin
        state_d = RUN;
        mcnt_d  = '0;
      end
    endcase
  end

  // Saturate rather than wrap so a long stall never reads as a short one
  always_comb begin
    scnt_d = scnt_q;
    if (stall && (scnt_q != '1)) begin
      scnt_d = scnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (1'b1)
      ex_branch_taken: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      stall: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
    mdu_busy = (state_q == MDU);
    mdu_done = (state_q == MDU) & last;
    // Hold the pipeline frozen with a nop in ID/EX while in reset
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      mdu_busy    = 1'b0;
      mdu_done    = 1'b0;
    end
  end

  assign stall_cnt = scnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus random traffic
// against a cycle-level reference model with a busy-cycle countdown.
module tb_hazard_stall_unit;

  localparam int LAT   = 4;
  localparam int CNT_W = 16;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             id_mdu_start;
  logic             id_reads_hilo;
  logic             ex_branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int m_rem  = 0;
  int m_sc   = 0;

  hazard_stall_unit #(
    .MDU_LATENCY(LAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread),
    .idex_rt(idex_rt),
    .id_mdu_start(id_mdu_start),
    .id_reads_hilo(id_reads_hilo),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write),
    .ifid_write(ifid_write),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .mdu_busy(mdu_busy),
    .mdu_done(mdu_done),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stall();
    bit lu;
    bit hold;
    lu = idex_memread && idex_rt != 0 &&
         (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
    hold = (m_rem > 0) && (id_mdu_start || id_reads_hilo);
    return (lu || hold) && !ex_branch_taken;
  endfunction

  function automatic logic [5:0] m_outs();
    logic [3:0] c;
    if (ex_branch_taken) c = 4'b1111;
    else if (m_stall())  c = 4'b0001;
    else                 c = 4'b1100;
    return {c, m_rem > 0, m_rem == 1};
  endfunction

  task automatic tick(input string tag);
    bit s;
    @(negedge clk);
    chk({tag, ".ctl"},
        {26'd0, pc_write, ifid_write, ifid_flush,
         idex_bubble, mdu_busy, mdu_done},
        {26'd0, m_outs()});
    chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_sc));
    s = m_stall();
    @(posedge clk);
    if (s && m_sc < SMAX) m_sc++;
    if (m_rem > 0) m_rem--;
    else if (id_mdu_start && !s && !ex_branch_taken) m_rem = LAT;
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = 5'd0;
    id_mdu_start = 1'b0; id_reads_hilo = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    chk("rst.ctl",
        {26'd0, pc_write, ifid_write, ifid_flush,
         idex_bubble, mdu_busy, mdu_done}, 32'b001100);
    chk("rst.cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;

    // load-use on rs
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    tick("lu_rs");
    idle();
    tick("lu_after");
    chk("lu_cnt1", 32'(stall_cnt), 32'd1);

    // r0 destination and unused rt never stall
    idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    tick("lu_r0");
    idex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    tick("lu_rt_unused");
    id_uses_rt = 1'b1;
    tick("lu_rt_used");
    idle();

    // mult issue then mflo held through the busy window
    id_mdu_start = 1'b1;
    tick("mdu_issue");
    id_mdu_start = 1'b0; id_reads_hilo = 1'b1;
    for (int i = 0; i < LAT + 2; i++) tick("mflo_hold");
    idle();
    chk("mdu_cnt", 32'(stall_cnt), 32'd6);

    // branch beats load-use and mdu_start
    idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4;
    id_mdu_start = 1'b1; ex_branch_taken = 1'b1;
    tick("br_prio");
    idle();
    tick("br_no_issue");
    chk("br_busy", {31'd0, mdu_busy}, 32'd0);

    // load-use delays an mdu issue
    idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
    id_mdu_start = 1'b1;
    tick("lu_mdu");
    idex_memread = 1'b0;
    tick("mdu_late_issue");
    id_mdu_start = 1'b0;
    tick("mdu_run1");
    tick("mdu_run2");

    // reset mid-MDU abandons the op
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", {31'd0, mdu_busy}, 32'd0);
    chk("rst_mid.cnt", 32'(stall_cnt), 32'd0);
    m_rem = 0; m_sc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    id_mdu_start = 1'b1;
    tick("post_rst_issue");
    id_mdu_start = 1'b0;
    chk("post_rst_busy", {31'd0, mdu_busy}, 32'd1);
    for (int i = 0; i < LAT; i++) tick("post_rst_drain");

    // random traffic, including flushes inside the MDU window
    for (int i = 0; i < 600; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      idex_memread = ($urandom_range(0, 2) == 0);
      idex_rt = 5'($urandom_range(0, 3));
      id_mdu_start = ($urandom_range(0, 3) == 0);
      id_reads_hilo = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      tick("rand");
    end
    idle();
    for (int i = 0; i < LAT + 1; i++) tick("drain");

    // saturation
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    for (int i = 0; i < SMAX + 6; i++) tick("sat");
    chk("sat_final", 32'(stall_cnt), 32'(SMAX));
    idle();
    tick("sat_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
